phase_counter: RTL

PHASE_COUNTER -- requirements
Module: phase_counter

---
 rtl/phase_counter.sv | 133 +++++++++++++
 1 files changed

// File: rtl/phase_counter.sv
// Phase correlation counter for an oscillator matrix.
// Synchronizes the bottom-row phase bits, then, over a programmable window,
// counts for each oscillator how many cycles it agreed with the reference
// oscillator (bit N-1). When the window ends, a spin decision is taken per
// oscillator by majority vote against half the window length.
module phase_counter #(
   parameter int N           = 8,
   parameter int CNT_W       = 16,
   parameter int SYNC_STAGES = 2
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [N-1:0]     bot_row,
   input  logic             start,
   input  logic [CNT_W-1:0] window,
   output logic             busy,
   output logic             done,
   output logic [N-1:0]     spins,
   input  logic [7:0]       rd_sel,
   output logic [31:0]      rd_data
);

   localparam int               IDX_W   = (N > 1) ? $clog2(N) : 1;
   localparam logic [CNT_W-1:0] CNT_MAX = '1;
   localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

   typedef enum logic [1:0] {
      IDLE,
      RUN,
      DONE
   } state_t;

   state_t           state;
   state_t           state_nxt;
   logic             clear;

   logic [N-1:0]     sync_q [SYNC_STAGES];
   logic [N-1:0]     s;

   logic [CNT_W-1:0] remaining;
   logic [CNT_W-1:0] win_len;
   logic [CNT_W-1:0] win_len_nxt;
   logic [CNT_W-1:0] count     [N];
   logic [CNT_W-1:0] count_nxt [N];
   logic [N-1:0]     spins_nxt;
   logic [IDX_W-1:0] rd_idx;

   // Metastability chain: every phase bit passes through SYNC_STAGES flops.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int k = 0; k < SYNC_STAGES; k++) sync_q[k] <= '0;
      end else begin
         // NOTE: non-blocking assignments make every stage take the previous
         // stage's old value, so the chain really is SYNC_STAGES deep.
         sync_q[0] <= bot_row;
         for (int k = 1; k < SYNC_STAGES; k++) sync_q[k] <= sync_q[k-1];
      end
   end

   assign s = sync_q[SYNC_STAGES-1];

   // Next-state logic; a start is only honoured from IDLE.
   always_comb begin
      // NOTE: defaults first so no path through the case leaves a signal
      // unassigned, which would otherwise infer a latch.
      state_nxt = state;
      clear     = 1'b0;
      case (state)
         IDLE: begin
            if (start) begin
               clear     = 1'b1;
               state_nxt = (window == '0) ? DONE : RUN;
            end
         end
         RUN:     if (remaining == CNT_ONE) state_nxt = DONE;
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // Counter update and the spin vote on the values the counters are about to hold.
   always_comb begin
      win_len_nxt = clear ? window : win_len;
      spins_nxt   = '0;
      for (int i = 0; i < N; i++) begin
         count_nxt[i] = count[i];
         if (clear) begin
            count_nxt[i] = '0;
         end else if (state == RUN && s[i] == s[N-1] && count[i] != CNT_MAX) begin
            count_nxt[i] = count[i] + CNT_ONE;
         end
         spins_nxt[i] = (count_nxt[i] > (win_len_nxt >> 1));
      end
   end

   // State, window bookkeeping, counters and spin register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= IDLE;
         remaining <= '0;
         win_len   <= '0;
         spins     <= '0;
         // NOTE: the counter array is reset explicitly because it is
         // software-visible through rd_data and must read zero after reset.
         for (int i = 0; i < N; i++) count[i] <= '0;
      end else begin
         state   <= state_nxt;
         win_len <= win_len_nxt;
         for (int i = 0; i < N; i++) count[i] <= count_nxt[i];
         if (clear) begin
            remaining <= window;
         end else if (state == RUN) begin
            remaining <= remaining - CNT_ONE;
         end
         // Spins become valid together with the done pulse and then hold.
         if (state_nxt == DONE) spins <= spins_nxt;
      end
   end

   assign busy   = (state != IDLE);
   assign done   = (state == DONE);
   assign rd_idx = rd_sel[IDX_W-1:0];

   // Readout mux: live counter value, or a recognisable filler for bad indices.
   always_comb begin
      rd_data = 32'hAAAA_AAAA;
      if ({24'd0, rd_sel} < 32'(N)) begin
         rd_data              = '0;
         rd_data[CNT_W-1:0]   = count[rd_idx];
      end
   end

endmodule
